// File: rtl/random_roller_mc.sv
// rtl/random_roller_mc.sv - multi-channel slot-machine LFSR roller with circular roll history
// Optional macro RR_STOP_ON_START_EN: i_start during a roll forces an immediate final update.
module random_roller_mc #(
   parameter int NUM_CH      = 2,
   parameter int OUT_W       = 4,
   parameter int HIST_DEPTH  = 4,
   parameter int BASE_PERIOD = 2500000,
   parameter int NUM_STEPS   = 16
) (
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   input  logic                             i_start,
   input  logic                             i_mem,
   output logic [NUM_CH*OUT_W-1:0]          o_random_out,
   output logic [NUM_CH*OUT_W-1:0]          o_random_mem_out,
   output logic                             o_busy,
   output logic                             o_done,
   output logic [$clog2(HIST_DEPTH+1)-1:0]  o_hist_cnt
);

   localparam int DW    = NUM_CH * OUT_W;
   localparam int CNT_W = $clog2(BASE_PERIOD * NUM_STEPS + 1);
   localparam int K_W   = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
   localparam int PTR_W = $clog2(HIST_DEPTH);
   localparam int HC_W  = $clog2(HIST_DEPTH + 1);

   typedef enum logic {S_IDLE, S_ROLL} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, lim_q, lim_d;
   logic [K_W-1:0]    k_q, k_d;
   logic [DW-1:0]     out_q;
   logic              done_q;
   logic              load, push, stop_req;

   logic [15:0]       lfsr_q [NUM_CH];
   logic [DW-1:0]     ch_val;

   logic [DW-1:0]     hist_q [HIST_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_off_q, rd_idx;
   logic [HC_W-1:0]   hcnt_q;
   logic [DW-1:0]     mem_out_q;
   logic              mem_step;

`ifdef RR_STOP_ON_START_EN
   assign stop_req = i_start;
`else
   assign stop_req = 1'b0;
`endif

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         ch_val[c*OUT_W +: OUT_W] = lfsr_q[c][OUT_W-1:0];
      end
   end

   // Free-running generators; the FSM only decides when to sample them.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            lfsr_q[c] <= 16'hACE1 + 16'(c) * 16'h1357;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            lfsr_q[c] <= {lfsr_q[c][14:0],
                          lfsr_q[c][15] ^ lfsr_q[c][13] ^ lfsr_q[c][12] ^ lfsr_q[c][10]};
         end
      end
   end

   // lim tracks BASE_PERIOD*(k+1)-1 incrementally, so no multiplier is needed.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      k_d     = k_q;
      lim_d   = lim_q;
      load    = 1'b0;
      push    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d = S_ROLL;
               cnt_d   = '0;
               k_d     = '0;
               lim_d   = CNT_W'(BASE_PERIOD - 1);
            end
         end
         S_ROLL: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == lim_q || stop_req) begin
               load  = 1'b1;
               cnt_d = '0;
               k_d   = k_q + K_W'(1);
               lim_d = lim_q + CNT_W'(BASE_PERIOD);
               if (k_q == K_W'(NUM_STEPS - 1) || stop_req) begin
                  push    = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         lim_q   <= '0;
         k_q     <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lim_q   <= lim_d;
         k_q     <= k_d;
         done_q  <= push;
         if (load) begin
            out_q <= ch_val;
         end
      end
   end

   // rd_off counts back from the newest entry; start has priority over mem.
   assign mem_step = (state_q == S_IDLE) && i_mem && !i_start && (hcnt_q != '0);
   assign rd_idx   = wr_ptr_q - PTR_W'(1) - rd_off_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < HIST_DEPTH; i++) begin
            hist_q[i] <= '0;
         end
         wr_ptr_q  <= '0;
         rd_off_q  <= '0;
         hcnt_q    <= '0;
         mem_out_q <= '0;
      end else if (push) begin
         hist_q[wr_ptr_q] <= ch_val;
         wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
         rd_off_q         <= '0;
         if (hcnt_q != HC_W'(HIST_DEPTH)) begin
            hcnt_q <= hcnt_q + HC_W'(1);
         end
      end else if (mem_step) begin
         mem_out_q <= hist_q[rd_idx];
         if (HC_W'(rd_off_q) + HC_W'(1) == hcnt_q) begin
            rd_off_q <= '0;
         end else begin
            rd_off_q <= rd_off_q + PTR_W'(1);
         end
      end
   end

   assign o_random_out     = out_q;
   assign o_random_mem_out = mem_out_q;
   assign o_busy           = (state_q == S_ROLL);
   assign o_done           = done_q;
   assign o_hist_cnt       = hcnt_q;

endmodule
